mult_scheduler: RTL



---
 rtl/mult_pkg.sv | 18 +
 rtl/shift_add_core.sv | 40 ++++
 rtl/mult_scheduler.sv | 126 ++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared types and defaults for the multiplier scheduler.
// State encoding, default sizes and the id-width helper.
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   localparam int DEF_SIZE = 6;
   localparam int DEF_NREQ = 4;

   function automatic int idw(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/shift_add_core.sv
// Sequential shift-add multiplier datapath.
// Holds the shifting multiplier, the shifted multiplicand and the accumulator.
module shift_add_core
   import mult_pkg::*;
#(
   parameter int SIZE = DEF_SIZE
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [SIZE-1:0]   a,
   input  logic [SIZE-1:0]   b,
   input  logic              step,
   output logic [2*SIZE-1:0] product
);

   logic [SIZE-1:0]   a_q;
   logic [2*SIZE-1:0] b_q;
   logic [2*SIZE-1:0] acc;

   // Accumulator value including the partial sum of the current step.
   assign product = acc + (a_q[0] ? b_q : '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q <= '0;
         b_q <= '0;
         acc <= '0;
      end else if (load) begin
         a_q <= a;
         b_q <= {{SIZE{1'b0}}, b};
         acc <= '0;
      end else if (step) begin
         a_q <= a_q >> 1;
         b_q <= b_q << 1;
         acc <= product;
      end
   end

endmodule

// File: rtl/mult_scheduler.sv
// Round-robin scheduler sharing one shift-add multiplier among requesters.
// Grants in IDLE, steps the core in RUN, presents the tagged result in DONE.
module mult_scheduler
   import mult_pkg::*;
#(
   parameter int SIZE = DEF_SIZE,
   parameter int NREQ = DEF_NREQ,
   localparam int IDW = idw(NREQ)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NREQ-1:0]    req_valid,
   output logic [NREQ-1:0]    req_ready,
   input  logic [NREQ*SIZE-1:0] req_a,
   input  logic [NREQ*SIZE-1:0] req_b,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [IDW-1:0]     rsp_id,
   output logic [2*SIZE-1:0]  rsp_product,
   output logic               busy
);

   localparam int CW = idw(SIZE);

   state_t            state;
   state_t            nstate;
   logic [CW-1:0]     cnt;
   logic [IDW-1:0]    last_q;
   logic [IDW-1:0]    id_q;
   logic [2*SIZE-1:0] result;
   logic [NREQ-1:0]   grant;
   logic [IDW-1:0]    win_id;
   logic              found;
   logic              load;
   logic              step;
   logic [SIZE-1:0]   sel_a;
   logic [SIZE-1:0]   sel_b;
   logic [2*SIZE-1:0] core_product;

   // Search starts one past the last served requester.
   always_comb begin
      grant  = '0;
      win_id = '0;
      found  = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         int idx;
         idx = (int'(last_q) + k) % NREQ;
         if (!found && req_valid[idx]) begin
            grant[idx] = 1'b1;
            win_id     = IDW'(idx);
            found      = 1'b1;
         end
      end
   end

   assign sel_a = req_a[int'(win_id)*SIZE +: SIZE];
   assign sel_b = req_b[int'(win_id)*SIZE +: SIZE];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nstate;
   end

   always_comb begin
      nstate    = state;
      req_ready = '0;
      rsp_valid = 1'b0;
      busy      = 1'b1;
      load      = 1'b0;
      step      = 1'b0;
      unique case (state)
         IDLE: begin
            busy      = 1'b0;
            req_ready = grant;
            if (found) begin
               load   = 1'b1;
               nstate = RUN;
            end
         end
         RUN: begin
            step = 1'b1;
            if (cnt == '0) nstate = DONE;
         end
         DONE: begin
            rsp_valid = 1'b1;
            if (rsp_ready) nstate = IDLE;
         end
         default: nstate = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         last_q <= IDW'(NREQ - 1);
         id_q   <= '0;
         result <= '0;
      end else begin
         if (load) begin
            cnt  <= CW'(SIZE - 1);
            id_q <= win_id;
         end
         if (state == RUN) begin
            if (cnt == '0) result <= core_product;
            else           cnt    <= cnt - 1'b1;
         end
         if (state == DONE && rsp_ready) last_q <= id_q;
      end
   end

   assign rsp_id      = id_q;
   assign rsp_product = result;

   shift_add_core #(
      .SIZE (SIZE)
   ) u_core (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load),
      .a       (sel_a),
      .b       (sel_b),
      .step    (step),
      .product (core_product)
   );

endmodule
